// File: rtl/adder_arb_pkg.sv
// Shared types and constants for the round-robin adder arbiter.
package adder_arb_pkg;

  // Output register occupancy: IDLE = empty, RESP = holding a result.
  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_NREQ  = 4;

  localparam int          COUNT_W   = 8;
  localparam logic [7:0]  COUNT_MAX = 8'hFF;

  // Requester-index width; a single requester still gets a 1-bit id port.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/add_core.sv
// Purely combinational WIDTH-bit adder with carry-out; the one adder shared
// by every requester.
module add_core #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  assign {carry, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin arbiter feeding a single shared adder. One result register
// holds the sum; a new requester can be accepted in the same cycle the
// held result is taken downstream, giving one result per cycle.
module adder_arbiter
  import adder_arb_pkg::*;
#(
  parameter  int NREQ  = DEF_NREQ,
  parameter  int WIDTH = DEF_WIDTH,
  localparam int ID_W  = id_width(NREQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*WIDTH-1:0]   req_a,
  input  logic [NREQ*WIDTH-1:0]   req_b,
  output logic [NREQ-1:0]         req_ready,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [WIDTH-1:0]        rsp_sum,
  output logic                    rsp_carry,
  output logic [ID_W-1:0]         rsp_id,
  output logic [COUNT_W-1:0]      txn_count
);

  state_t            state_reg, state_next;
  logic [ID_W-1:0]   ptr_reg, ptr_next;

  logic              can_accept;
  logic              gnt_any;
  logic [ID_W-1:0]   gnt_idx;
  logic [NREQ-1:0]   grant;

  logic [WIDTH-1:0]  a_masked [NREQ];
  logic [WIDTH-1:0]  b_masked [NREQ];
  logic [WIDTH-1:0]  sel_a, sel_b;
  logic [WIDTH-1:0]  add_sum;
  logic              add_carry;

  logic              handshake;

  // A new grant is possible when the register is empty or is being drained.
  assign can_accept = (state_reg == IDLE) || rsp_ready;
  assign handshake  = (state_reg == RESP) && rsp_ready;

  // Round-robin search starting at ptr_reg; looks only at req_valid, never
  // at operands. Held off entirely while reset is asserted.
  always_comb begin
    logic [ID_W-1:0] cand;
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int off = 0; off < NREQ; off++) begin
      cand = ID_W'((int'(ptr_reg) + off) % NREQ);
      if (!gnt_any && req_valid[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
    if (!can_accept || !rst_n) begin
      gnt_any = 1'b0;
    end
  end

  // One-hot grant from the winning index.
  always_comb begin
    grant = '0;
    if (gnt_any) begin
      grant[gnt_idx] = 1'b1;
    end
  end

  assign req_ready = grant;

  // AND-OR operand mux driven by the one-hot grant.
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_mask
      assign a_masked[gi] = grant[gi] ? req_a[gi*WIDTH +: WIDTH] : '0;
      assign b_masked[gi] = grant[gi] ? req_b[gi*WIDTH +: WIDTH] : '0;
    end
  endgenerate

  // OR-reduce the masked operands into the adder inputs.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      sel_a = sel_a | a_masked[i];
      sel_b = sel_b | b_masked[i];
    end
  end

  add_core #(
    .WIDTH (WIDTH)
  ) u_add_core (
    .a     (sel_a),
    .b     (sel_b),
    .sum   (add_sum),
    .carry (add_carry)
  );

  // Next state and pointer: a grant always fills the register; draining
  // without a new grant empties it.
  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    if (gnt_any) begin
      state_next = RESP;
      ptr_next   = (gnt_idx == ID_W'(NREQ - 1)) ? '0 : gnt_idx + ID_W'(1);
    end else if (handshake) begin
      state_next = IDLE;
    end
  end

  // State and round-robin pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
    end
  end

  // Result register: loads the shared adder output on every grant and holds
  // otherwise, so it stays stable under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_sum   <= '0;
      rsp_carry <= 1'b0;
      rsp_id    <= '0;
    end else if (gnt_any) begin
      rsp_sum   <= add_sum;
      rsp_carry <= add_carry;
      rsp_id    <= gnt_idx;
    end
  end

  // Saturating count of results taken downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txn_count <= '0;
    end else if (handshake && (txn_count != COUNT_MAX)) begin
      txn_count <= txn_count + COUNT_W'(1);
    end
  end

  assign rsp_valid = (state_reg == RESP);

endmodule

// File: tb/tb_adder_arbiter.sv
// Self-checking bench for adder_arbiter: a reference model predicts grants
// and results; expected results go into a scoreboard queue at grant time and
// are compared when the DUT presents them.
module tb_adder_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 4;
  localparam int ID_W  = 2;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b1;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ*WIDTH-1:0] req_a = '0;
  logic [NREQ*WIDTH-1:0] req_b = '0;
  logic                  rsp_ready = 1'b0;
  logic [NREQ-1:0]       req_ready;
  logic                  rsp_valid;
  logic [WIDTH-1:0]      rsp_sum;
  logic                  rsp_carry;
  logic [ID_W-1:0]       rsp_id;
  logic [7:0]            txn_count;

  adder_arbiter #(
    .NREQ  (NREQ),
    .WIDTH (WIDTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_carry (rsp_carry),
    .rsp_id    (rsp_id),
    .txn_count (txn_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ID_W-1:0]  id;
    logic [WIDTH-1:0] sum;
    logic             carry;
  } exp_t;

  exp_t sb[$];
  int   gnt_log[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state
  bit   m_full  = 1'b0;
  int   m_ptr   = 0;
  int   m_count = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Model + scoreboard, evaluated once per cycle on the falling edge.
  always @(negedge clk) begin
    int         g;
    bit         can;
    logic [4:0] s;
    logic [3:0] exp_ready;
    exp_t       e;
    if (!rst_n) begin
      check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check_eq("rst_req_ready", 32'(req_ready), 32'd0);
      check_eq("rst_txn_count", 32'(txn_count), 32'd0);
      check_eq("rst_rsp_sum", 32'({rsp_carry, rsp_id, rsp_sum}), 32'd0);
      sb.delete();
      m_full  = 1'b0;
      m_ptr   = 0;
      m_count = 0;
    end else begin
      check_eq("rsp_valid", 32'(rsp_valid), 32'(m_full));
      check_eq("txn_count", 32'(txn_count), 32'(m_count));
      if (m_full) begin
        if (sb.size() == 0) begin
          check_eq("sb_empty", 32'd1, 32'd0);
        end else begin
          e = sb[0];
          check_eq("rsp_sum", 32'(rsp_sum), 32'(e.sum));
          check_eq("rsp_carry", 32'(rsp_carry), 32'(e.carry));
          check_eq("rsp_id", 32'(rsp_id), 32'(e.id));
          if (rsp_ready) begin
            void'(sb.pop_front());
            if (m_count < 255) m_count++;
          end
        end
      end
      can = !m_full || rsp_ready;
      g = -1;
      if (can) begin
        for (int off = 0; off < NREQ; off++) begin
          if (g < 0 && req_valid[(m_ptr + off) % NREQ]) g = (m_ptr + off) % NREQ;
        end
      end
      exp_ready = (g >= 0) ? 4'(1 << g) : 4'd0;
      check_eq("req_ready", 32'(req_ready), 32'(exp_ready));
      for (int i = 0; i < NREQ; i++) begin
        if (req_ready[i]) gnt_log.push_back(i);
      end
      if (g >= 0) begin
        s = {1'b0, req_a[g*WIDTH +: WIDTH]} + {1'b0, req_b[g*WIDTH +: WIDTH]};
        e.id    = ID_W'(g);
        e.sum   = s[3:0];
        e.carry = s[4];
        sb.push_back(e);
        m_full = 1'b1;
        m_ptr  = (g + 1) % NREQ;
      end else if (m_full && rsp_ready) begin
        m_full = 1'b0;
      end
    end
  end

  initial begin
    #1 rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;

    // Basic: req0 3+4
    req_valid = 4'b0001;
    req_a[3:0] = 4'd3;
    req_b[3:0] = 4'd4;
    rsp_ready = 1'b1;
    cyc(1);
    req_valid = 4'b0000;
    check_eq("first_valid", 32'(rsp_valid), 32'd1);
    check_eq("first_sum", 32'(rsp_sum), 32'd7);
    check_eq("first_carry", 32'(rsp_carry), 32'd0);
    check_eq("first_id", 32'(rsp_id), 32'd0);
    cyc(1);
    check_eq("first_count", 32'(txn_count), 32'd1);

    // Overflow: req2 9+8
    req_valid = 4'b0100;
    req_a[11:8] = 4'd9;
    req_b[11:8] = 4'd8;
    cyc(1);
    req_valid = 4'b0000;
    check_eq("ovf_sum", 32'(rsp_sum), 32'd1);
    check_eq("ovf_carry", 32'(rsp_carry), 32'd1);
    check_eq("ovf_id", 32'(rsp_id), 32'd2);
    cyc(1);

    // Backpressure: req1 5+6 then stall 3 cycles with everyone requesting
    req_valid = 4'b0010;
    req_a[7:4] = 4'd5;
    req_b[7:4] = 4'd6;
    cyc(1);
    req_valid = 4'b1111;
    rsp_ready = 1'b0;
    cyc(3);
    check_eq("bp_sum", 32'(rsp_sum), 32'd11);
    check_eq("bp_id", 32'(rsp_id), 32'd1);
    req_valid = 4'b0000;
    rsp_ready = 1'b1;
    cyc(1);
    check_eq("bp_single", 32'(rsp_valid), 32'd0);

    // Reset while a result is held, then all requesters valid
    req_valid = 4'b1111;
    rsp_ready = 1'b0;
    cyc(1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("async_txn_count", 32'(txn_count), 32'd0);
    rsp_ready = 1'b1;
    cyc(1);
    rst_n = 1'b1;
    gnt_log.delete();
    cyc(5);
    check_eq("rr_log_len", 32'(gnt_log.size()), 32'd5);
    for (int i = 0; i < 5 && i < gnt_log.size(); i++) begin
      check_eq($sformatf("rr_grant%0d", i), 32'(gnt_log[i]), 32'(i % NREQ));
    end

    // Saturation
    for (int i = 0; i < 260; i++) begin
      req_a = 16'($urandom);
      req_b = 16'($urandom);
      cyc(1);
    end
    check_eq("sat_count", 32'(txn_count), 32'd255);

    // Random traffic with random backpressure
    for (int i = 0; i < 300; i++) begin
      req_valid = 4'($urandom_range(0, 15));
      req_a     = 16'($urandom);
      req_b     = 16'($urandom);
      rsp_ready = ($urandom_range(0, 9) < 7);
      cyc(1);
    end
    req_valid = 4'b0000;
    rsp_ready = 1'b1;
    cyc(3);
    check_eq("drain_valid", 32'(rsp_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
